// File: rtl/uart_core.sv
// uart_core: shared baud-tick generator with 8N1 transmitter and receiver.
// Define UART_FRAME_CHECK_EN to drop received frames whose stop bit samples as 0.
module uart_core #(
    parameter int SIZE_DATA      = 8,
    parameter int OVER_SAMPLE    = 16,
    parameter int MID_SAMPLE     = 8,
    parameter int SIZE_BAUD      = 24,
    parameter int BAUDRATE_VALUE = 325
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_en,
    input  logic                 i_fifo_empty,
    input  logic [SIZE_DATA-1:0] i_tx_data,
    output logic                 o_tx_serial,
    output logic                 o_tx_done,
    input  logic                 i_rx_en,
    input  logic                 i_fifo_full,
    input  logic                 i_rx_serial,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_done,
    output logic                 o_stick
);
    localparam int TW = $clog2(OVER_SAMPLE);
    localparam int BW = $clog2(SIZE_DATA);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [SIZE_BAUD-1:0] r_baud_cnt;
    logic                 w_tick;

    assign w_tick  = (r_baud_cnt == SIZE_BAUD'(BAUDRATE_VALUE - 1));
    assign o_stick = w_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_baud_cnt <= '0;
        else          r_baud_cnt <= w_tick ? '0 : r_baud_cnt + SIZE_BAUD'(1);
    end

    state_t               r_tx_state;
    logic [TW-1:0]        r_tx_tick;
    logic [BW-1:0]        r_tx_bit;
    logic [SIZE_DATA-1:0] r_tx_shift;
    logic                 r_tx_serial;
    logic                 r_tx_done;
    logic                 w_tx_last;

    assign w_tx_last   = (r_tx_tick == TW'(OVER_SAMPLE - 1));
    assign o_tx_serial = r_tx_serial;
    assign o_tx_done   = r_tx_done;

    // Frames start on a tick so every bit lasts exactly OVER_SAMPLE tick periods.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state  <= IDLE;
            r_tx_tick   <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_serial <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_tx_state)
                IDLE: begin
                    r_tx_serial <= 1'b1;
                    if (w_tick && i_tx_en && !i_fifo_empty) begin
                        r_tx_shift  <= i_tx_data;
                        r_tx_serial <= 1'b0;
                        r_tx_tick   <= '0;
                        r_tx_state  <= START;
                    end
                end
                START: if (w_tick) begin
                    if (w_tx_last) begin
                        r_tx_tick   <= '0;
                        r_tx_bit    <= '0;
                        r_tx_serial <= r_tx_shift[0];
                        r_tx_state  <= DATA;
                    end else r_tx_tick <= r_tx_tick + TW'(1);
                end
                DATA: if (w_tick) begin
                    if (w_tx_last) begin
                        r_tx_tick <= '0;
                        if (r_tx_bit == BW'(SIZE_DATA - 1)) begin
                            r_tx_serial <= 1'b1;
                            r_tx_state  <= STOP;
                        end else begin
                            r_tx_serial <= r_tx_shift[1];
                            r_tx_shift  <= r_tx_shift >> 1;
                            r_tx_bit    <= r_tx_bit + BW'(1);
                        end
                    end else r_tx_tick <= r_tx_tick + TW'(1);
                end
                STOP: if (w_tick) begin
                    if (w_tx_last) begin
                        r_tx_tick  <= '0;
                        r_tx_done  <= 1'b1;
                        r_tx_state <= IDLE;
                    end else r_tx_tick <= r_tx_tick + TW'(1);
                end
            endcase
        end
    end

    state_t               r_rx_state;
    logic [TW-1:0]        r_rx_tick;
    logic [BW-1:0]        r_rx_bit;
    logic [SIZE_DATA-1:0] r_rx_shift;
    logic [SIZE_DATA-1:0] r_rx_data;
    logic                 r_rx_done;
    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic                 w_rx_fall;
    logic                 w_rx_last;

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;
    assign w_rx_last = (r_rx_tick == TW'(OVER_SAMPLE - 1));
    assign o_rx_data = r_rx_data;
    assign o_rx_done = r_rx_done;

    // Start detection is edge based so a frame ignored while full is skipped entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_meta <= i_rx_serial;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_rx_done <= 1'b0;
            case (r_rx_state)
                IDLE: if (i_rx_en && !i_fifo_full && w_rx_fall) begin
                    r_rx_tick  <= '0;
                    r_rx_state <= START;
                end
                START: if (w_tick) begin
                    if (r_rx_tick == TW'(MID_SAMPLE - 1)) begin
                        r_rx_tick  <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? IDLE : DATA;
                    end else r_rx_tick <= r_rx_tick + TW'(1);
                end
                DATA: if (w_tick) begin
                    if (w_rx_last) begin
                        r_rx_tick  <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[SIZE_DATA-1:1]};
                        r_rx_bit   <= r_rx_bit + BW'(1);
                        if (r_rx_bit == BW'(SIZE_DATA - 1)) r_rx_state <= STOP;
                    end else r_rx_tick <= r_rx_tick + TW'(1);
                end
                STOP: if (w_tick) begin
                    if (w_rx_last) begin
                        r_rx_tick  <= '0;
                        r_rx_state <= IDLE;
`ifdef UART_FRAME_CHECK_EN
                        if (r_rx_sync) begin
                            r_rx_data <= r_rx_shift;
                            r_rx_done <= 1'b1;
                        end
`else
                        r_rx_data <= r_rx_shift;
                        r_rx_done <= 1'b1;
`endif
                    end else r_rx_tick <= r_rx_tick + TW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven and randomized loopback checks of uart_core.
module tb_uart_core;
    localparam int B   = 5;
    localparam int OS  = 16;
    localparam int BIT = B * OS;

    logic       clk = 0, rst_n = 0;
    logic       tx_en = 0, fifo_empty = 1, rx_en = 0, fifo_full = 0;
    logic       loop = 1, drv_rx = 1;
    logic [7:0] tx_data = 0;
    logic       rx_serial, tx_serial, tx_done, rx_done, stick;
    logic [7:0] rx_data;

    assign rx_serial = loop ? tx_serial : drv_rx;

    uart_core #(.BAUDRATE_VALUE(B)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
        .i_tx_data(tx_data), .o_tx_serial(tx_serial), .o_tx_done(tx_done),
        .i_rx_en(rx_en), .i_fifo_full(fifo_full), .i_rx_serial(rx_serial),
        .o_rx_data(rx_data), .o_rx_done(rx_done), .o_stick(stick)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, rx_cnt = 0, tx_cnt = 0, rx_t = 0, tx_t = 0;
    logic [7:0] model = 0;

    always @(negedge clk) begin
        cyc++;
        if (rx_done) begin rx_cnt++; rx_t = cyc; end
        if (tx_done) begin tx_cnt++; tx_t = cyc; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one frame, decode the line at mid-bit and wait for tx_done.
    task automatic send(input logic [7:0] b);
        int n;
        int t0;
        logic [9:0] bits;
        t0 = tx_cnt;
        tx_data = b; fifo_empty = 0; tx_en = 1;
        n = 0;
        while (tx_serial && n < 4 * BIT) begin @(negedge clk); n++; end
        fifo_empty = 1;
        chk("tx_start", {31'd0, tx_serial}, 0);
        if (tx_serial) return;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) repeat (BIT) @(negedge clk);
            bits[i] = tx_serial;
        end
        chk("tx_frame", {22'd0, bits}, {22'd0, 1'b1, b, 1'b0});
        n = 0;
        while (tx_cnt == t0 && n < BIT) begin @(negedge clk); n++; end
        chk("tx_done", tx_cnt - t0, 1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drv_rx = f[i];
            repeat (BIT - 1) @(negedge clk);
        end
        @(negedge clk); drv_rx = 1;
        repeat (BIT) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       full;
        logic       ren;
        logic       exp_done;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int n, r0, t0;
        logic idle_ok;
        tbl[0] = '{8'h29, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{8'h29, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h29, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{8'h80, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{8'h01, 1'b0, 1'b1, 1'b1};

        repeat (4) @(negedge clk);
        chk("rst_tx_serial", {31'd0, tx_serial}, 1);
        chk("rst_tx_done", {31'd0, tx_done}, 0);
        chk("rst_rx_done", {31'd0, rx_done}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_stick", {31'd0, stick}, 0);
        rst_n = 1;
        n = 0;
        while (!stick && n < 4 * B) begin @(negedge clk); n++; end
        chk("first_stick", (n == B - 1 || n == B) ? 1 : 0, 1);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!stick && n < 4 * B) begin @(negedge clk); n++; end
            chk("stick_period", n + 1, B);
        end
        idle_ok = 1;
        repeat (100) begin
            @(negedge clk);
            if (!tx_serial || tx_done || rx_done || rx_data != 0) idle_ok = 0;
        end
        chk("idle_quiet", {31'd0, idle_ok}, 1);

        foreach (tbl[i]) begin
            fifo_full = tbl[i].full; rx_en = tbl[i].ren;
            r0 = rx_cnt;
            send(tbl[i].data);
            repeat (3) @(negedge clk);
            fifo_full = 0;
            if (tbl[i].exp_done) model = tbl[i].data;
            chk("vec_rx_cnt", rx_cnt - r0, {31'd0, tbl[i].exp_done});
            chk("vec_rx_data", {24'd0, rx_data}, {24'd0, model});
            if (tbl[i].exp_done)
                chk("vec_rx_before_tx", (tx_t > rx_t && tx_t - rx_t <= BIT) ? 1 : 0, 1);
        end

        rx_en = 1;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            r0 = rx_cnt;
            send(b);
            repeat (3) @(negedge clk);
            model = b;
            chk("rand_rx_cnt", rx_cnt - r0, 1);
            chk("rand_rx_data", {24'd0, rx_data}, {24'd0, model});
        end

        t0 = tx_cnt;
        tx_en = 1; fifo_empty = 1;
        idle_ok = 1;
        repeat (2 * 10 * BIT) begin
            @(negedge clk);
            if (!tx_serial) idle_ok = 0;
        end
        chk("empty_line_high", {31'd0, idle_ok}, 1);
        chk("empty_no_done", tx_cnt - t0, 0);

        loop = 0; drv_rx = 1;
        repeat (BIT) @(negedge clk);
        r0 = rx_cnt;
        drv_rx = 0;
        repeat (10) @(negedge clk);
        drv_rx = 1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_no_done", rx_cnt - r0, 0);
        chk("glitch_data", {24'd0, rx_data}, {24'd0, model});

        r0 = rx_cnt;
        drive_frame(8'hA5, 1'b0);
`ifdef UART_FRAME_CHECK_EN
        chk("badstop_cnt", rx_cnt - r0, 0);
`else
        model = 8'hA5;
        chk("badstop_cnt", rx_cnt - r0, 1);
`endif
        chk("badstop_data", {24'd0, rx_data}, {24'd0, model});
        r0 = rx_cnt;
        drive_frame(8'h3C, 1'b1);
        model = 8'h3C;
        chk("manual_cnt", rx_cnt - r0, 1);
        chk("manual_data", {24'd0, rx_data}, {24'd0, model});

        loop = 1;
        tx_data = 8'h55; fifo_empty = 0; tx_en = 1;
        n = 0;
        while (tx_serial && n < 4 * BIT) begin @(negedge clk); n++; end
        fifo_empty = 1;
        repeat (3 * BIT) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_tx_serial", {31'd0, tx_serial}, 1);
        chk("midrst_tx_done", {31'd0, tx_done}, 0);
        chk("midrst_rx_done", {31'd0, rx_done}, 0);
        chk("midrst_rx_data", {24'd0, rx_data}, 0);
        chk("midrst_stick", {31'd0, stick}, 0);
        r0 = rx_cnt; t0 = tx_cnt;
        @(negedge clk); rst_n = 1;
        idle_ok = 1;
        repeat (12 * BIT) begin
            @(negedge clk);
            if (!tx_serial) idle_ok = 0;
        end
        chk("midrst_line", {31'd0, idle_ok}, 1);
        chk("midrst_no_rx", rx_cnt - r0, 0);
        chk("midrst_no_tx", tx_cnt - t0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

UART serial engine: a shared oversampling baud-tick generator, an 8N1 transmitter and an 8N1 receiver under one clock. The transmitter takes parallel bytes from an upstream TX FIFO; the receiver delivers bytes to a downstream RX FIFO. The default configuration is 9600 baud with 16x oversampling from a 50 MHz clock. The top loops `o_tx_serial` back to `i_rx_serial` for bring-up.

## Interface
- `SIZE_DATA`, 8: data bits per frame.
- `OVER_SAMPLE`, 16: baud ticks per bit.
- `MID_SAMPLE`, 8: ticks from the start-bit falling edge to the start-bit validation sample.
- `SIZE_BAUD`, 24: width of the baud counter.
- `BAUDRATE_VALUE`, 325: clock cycles per baud tick, computed as 50e6 / (9600 × 16), truncated.
- `i_clk`  in  1: the single clock.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_tx_en`  in  1: transmitter enable.
- `i_fifo_empty`  in  1: TX FIFO empty. The transmitter does not start a frame while this is 1.
- `i_tx_data`  in  SIZE_DATA: byte to transmit. Sampled at frame start.
- `o_tx_serial`  out  1: serial TX line, idle high.
- `o_tx_done`  out  1: one-cycle pulse at the end of the stop bit.
- `i_rx_en`  in  1: receiver enable.
- `i_fifo_full`  in  1: RX FIFO full. The receiver does not start a frame while this is 1.
- `i_rx_serial`  in  1: serial RX line, asynchronous.
- `o_rx_data`  out  SIZE_DATA: last received byte, held until the next update.
- `o_rx_done`  out  1: one-cycle pulse when `o_rx_data` updates.
- `o_stick`  out  1: baud tick, for observation.

## Operation
**Baud generator**
- The counter runs from 0 to BAUDRATE_VALUE−1 and then wraps to 0.
- `o_stick` = 1 for exactly one cycle at count BAUDRATE_VALUE−1.

**Transmitter** (states IDLE, START, DATA, STOP; all counting is done in ticks)
- IDLE: the line is 1.
  - On `i_tx_en`=1 and `i_fifo_empty`=0, latch `i_tx_data` and go to START.
- START: drive 0 for OVER_SAMPLE ticks.
- DATA: drive SIZE_DATA bits LSB first, OVER_SAMPLE ticks each.
- STOP: drive 1 for OVER_SAMPLE ticks.
  - Then pulse `o_tx_done` and return to IDLE.
  - If start conditions still hold, the next frame starts from IDLE without extra idle bits.
- Deasserting `i_tx_en` mid-frame does not abort the frame.

**Receiver** (states IDLE, START, DATA, STOP)
- `i_rx_serial` passes through a 2-flop synchronizer first.
- IDLE: with `i_rx_en`=1 and `i_fifo_full`=0, a synchronized 0 enters START.
- START: after MID_SAMPLE ticks, sample the line.
  - 0: go to DATA.
  - 1: a glitch; return to IDLE.
- DATA: sample every OVER_SAMPLE ticks, SIZE_DATA times, shifting bits in LSB first.
- STOP: after OVER_SAMPLE ticks, sample the stop bit.
  - Load `o_rx_data`, pulse `o_rx_done`, return to IDLE (subject to Configuration).
- Deasserting `i_rx_en` mid-frame does not abort the frame.

## Timing
- Reset values:
  - `o_tx_serial`=1; `o_tx_done`=0; `o_rx_data`=0; `o_rx_done`=0; `o_stick`=0.
  - All FSMs are in IDLE; all counters are 0.
- First `o_stick` occurs BAUDRATE_VALUE cycles after `i_rst_n` rises.
- TX:
  - `o_tx_serial` falls within one tick period of the start condition.
  - A frame lasts (SIZE_DATA+2) × OVER_SAMPLE ticks, which is 160 ticks = 52 000 cycles = 1.04 ms at the defaults.
- RX:
  - `o_rx_done` occurs about 9.5 bit times plus 2 synchronizer cycles after the start-bit falling edge.
  - In loopback, it comes within one bit time before `o_tx_done`.
- Reset asserted mid-frame returns all outputs to reset values immediately. No partial `done` pulse is issued.
- When `i_fifo_full`=1 at the start edge, that frame is ignored entirely. Reception resumes at the next falling edge seen in IDLE.

## Configuration
- `UART_FRAME_CHECK_EN` defined:
  - A stop bit sampled as 0 discards the frame.
  - `o_rx_data` is unchanged and `o_rx_done` is not pulsed.
- `UART_FRAME_CHECK_EN` undefined: the byte is always delivered and `o_rx_done` is pulsed, regardless of the stop-bit value.

## Test plan
- Reset, then idle 2 µs → `o_tx_serial`=1, outputs stay at reset values, `o_stick` period = 325 cycles.
- Loopback with `i_tx_data`=0x29, both enables high, FIFO flags 0 → serial bits 0,1,0,0,1,0,1,0,0,1 at 104 µs each; `o_rx_data`=0x29 with an `o_rx_done` pulse, then `o_tx_done` at 1.04 ms.
- `i_fifo_empty`=1 with `i_tx_en`=1 for 2 ms → line stays 1 and `o_tx_done` is never pulsed.
- `i_fifo_full`=1 during a 0x29 frame → no `o_rx_done`, `o_rx_data` holds its previous value. Clear the flag and send the next frame → 0x29 received.
- Inject a 2 µs low glitch on RX → rejected in START; no `o_rx_done`.
- Frame 0xA5 with stop bit forced to 0 → with `UART_FRAME_CHECK_EN`: no `o_rx_done`. Without it: `o_rx_data`=0xA5 and `o_rx_done` pulses.
